// File: rtl/i2s_out_sequencer.sv
// Frame scheduler and stereo sample FIFO feeding the I2S DAC serializer.
// Issues one ser_start per FRAME_BCLKS cycles and flags underflow / late frames.
module i2s_out_sequencer #(
   parameter int DATA_WIDTH  = 24,
   parameter int FRAME_BCLKS = 64,
   parameter int FIFO_DEPTH  = 4,
   parameter int PRIME_LEVEL = 2
) (
   input  logic                          BCLK,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic                          clear_status,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH-1:0]         in_left,
   input  logic [DATA_WIDTH-1:0]         in_right,
   output logic                          ser_start,
   output logic [DATA_WIDTH-1:0]         ser_left,
   output logic [DATA_WIDTH-1:0]         ser_right,
   input  logic                          ser_data_ready,
   output logic                          running,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underflow,
   output logic [15:0]                   underflow_count,
   output logic                          frame_error
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(FRAME_BCLKS);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PRIME = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;

   localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_BCLKS - 1);
   localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

   logic [1:0]            state, state_nxt;
   logic [CW-1:0]         frame_cnt, frame_cnt_nxt;
   logic                  launch, wrap, fifo_empty;
   logic                  push, pop, underflow_evt, frame_err_evt;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];

   // Upstream handshake: a pair transfers on every rising BCLK where in_valid
   // and in_ready are both high; in_ready depends only on the registered level.
   assign in_ready   = (fifo_level < DEPTH_LVL);
   assign fifo_empty = (fifo_level == '0);
   assign push       = in_valid && in_ready;
   assign wrap       = (state == RUN) && (frame_cnt == LAST_CNT);

   always_comb begin
      state_nxt     = state;
      frame_cnt_nxt = '0;
      launch        = 1'b0;
      case (state)
         IDLE: begin
            if (enable) state_nxt = PRIME;
         end
         PRIME: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (fifo_level >= PRIME_LVL) begin
               state_nxt = RUN;
               launch    = 1'b1;
            end
         end
         RUN: begin
            // A disable is only honoured at the frame boundary so the serializer
            // always finishes the frame it was given.
            if (!wrap)       frame_cnt_nxt = frame_cnt + CW'(1);
            else if (enable) launch        = 1'b1;
            else             state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign pop           = launch && !fifo_empty;
   assign underflow_evt = launch && fifo_empty;
   assign frame_err_evt = wrap && !ser_data_ready;

   always_ff @(posedge BCLK) begin
      if (!reset_n) begin
         state           <= IDLE;
         frame_cnt       <= '0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_level      <= '0;
         ser_start       <= 1'b0;
         ser_left        <= '0;
         ser_right       <= '0;
         running         <= 1'b0;
         underflow       <= 1'b0;
         underflow_count <= '0;
         frame_error     <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_cnt <= frame_cnt_nxt;
         ser_start <= launch;
         running   <= (state_nxt == RUN);

         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      fifo_level <= fifo_level + LW'(1);
         else if (pop && !push) fifo_level <= fifo_level - LW'(1);

         if (launch) begin
            ser_left  <= pop ? mem_l[rd_ptr] : '0;
            ser_right <= pop ? mem_r[rd_ptr] : '0;
         end

         // A fresh event outranks a simultaneous clear.
         if (underflow_evt) begin
            underflow <= 1'b1;
            if (clear_status)                     underflow_count <= 16'd1;
            else if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
         end else if (clear_status) begin
            underflow       <= 1'b0;
            underflow_count <= '0;
         end

         if (frame_err_evt)     frame_error <= 1'b1;
         else if (clear_status) frame_error <= 1'b0;
      end
   end

   always_ff @(posedge BCLK) begin
      if (push) begin
         mem_l[wr_ptr] <= in_left;
         mem_r[wr_ptr] <= in_right;
      end
   end

endmodule

// File: tb/tb_i2s_out_sequencer.sv
// Bench for i2s_out_sequencer: directed scenarios plus random traffic, every
// cycle compared against a frame-schedule model built on a sample queue.
module tb_i2s_out_sequencer;

   localparam int DW = 24;
   localparam int FB = 64;
   localparam int FD = 4;
   localparam int PL = 2;
   localparam int LW = 3;

   logic          BCLK = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic          clear_status = 1'b0;
   logic          in_valid = 1'b0;
   logic          ser_data_ready = 1'b1;
   logic [DW-1:0] in_left = '0;
   logic [DW-1:0] in_right = '0;
   logic          in_ready;
   logic          ser_start;
   logic [DW-1:0] ser_left;
   logic [DW-1:0] ser_right;
   logic          running;
   logic [LW-1:0] fifo_level;
   logic          underflow;
   logic [15:0]   underflow_count;
   logic          frame_error;

   i2s_out_sequencer #(
      .DATA_WIDTH(DW), .FRAME_BCLKS(FB), .FIFO_DEPTH(FD), .PRIME_LEVEL(PL)
   ) dut (
      .BCLK(BCLK), .reset_n(reset_n), .enable(enable), .clear_status(clear_status),
      .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
      .ser_start(ser_start), .ser_left(ser_left), .ser_right(ser_right),
      .ser_data_ready(ser_data_ready), .running(running), .fifo_level(fifo_level),
      .underflow(underflow), .underflow_count(underflow_count), .frame_error(frame_error)
   );

   always #5 BCLK = ~BCLK;

   // Reference: queued pairs plus the absolute cycle of the next frame boundary.
   logic [2*DW-1:0] exp_q[$];
   bit              m_armed, m_stream;
   int              m_next_due;
   logic            m_start, m_uf, m_ferr;
   logic [DW-1:0]   m_left, m_right;
   int              m_ufc;
   int              cyc, n_assert, n_fail, n_starts, last_start;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit launch, push, uf_evt, fe_evt;
      logic [2*DW-1:0] p;
      launch = 0; uf_evt = 0; fe_evt = 0;
      m_start = 1'b0;
      if (!reset_n) begin
         exp_q.delete();
         m_armed = 0; m_stream = 0; m_next_due = 0;
         m_left = '0; m_right = '0; m_uf = 1'b0; m_ufc = 0; m_ferr = 1'b0;
         return;
      end
      push = in_valid && (exp_q.size() < FD);
      if (m_stream) begin
         if (cyc == m_next_due) begin
            fe_evt = !ser_data_ready;
            if (enable) begin
               launch = 1; m_next_due = cyc + FB;
            end else begin
               m_stream = 0;
            end
         end
      end else if (m_armed) begin
         if (!enable) m_armed = 0;
         else if (exp_q.size() >= PL) begin
            m_armed = 0; m_stream = 1; launch = 1; m_next_due = cyc + FB;
         end
      end else if (enable) begin
         m_armed = 1;
      end
      if (launch) begin
         if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            m_left = p[2*DW-1:DW]; m_right = p[DW-1:0];
         end else begin
            m_left = '0; m_right = '0; uf_evt = 1;
         end
      end
      if (push) exp_q.push_back({in_left, in_right});
      m_start = launch;
      if (uf_evt) begin
         m_uf = 1'b1;
         if (clear_status) m_ufc = 1;
         else if (m_ufc < 65535) m_ufc++;
      end else if (clear_status) begin
         m_uf = 1'b0; m_ufc = 0;
      end
      if (fe_evt) m_ferr = 1'b1;
      else if (clear_status) m_ferr = 1'b0;
   endtask

   task automatic compare_all();
      check("ser_start", ser_start, m_start);
      check("ser_left", ser_left, m_left);
      check("ser_right", ser_right, m_right);
      check("running", running, m_stream);
      check("fifo_level", fifo_level, exp_q.size());
      check("in_ready", in_ready, exp_q.size() < FD);
      check("underflow", underflow, m_uf);
      check("underflow_count", underflow_count, m_ufc);
      check("frame_error", frame_error, m_ferr);
   endtask

   task automatic tick();
      @(posedge BCLK);
      cyc++;
      model_edge();
      #1;
      compare_all();
      if (ser_start === 1'b1) begin
         n_starts++;
         last_start = cyc;
      end
   endtask

   task automatic wait_start(input int budget, input string tag);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (ser_start === 1'b1) seen = 1;
      end
      check({tag, "_start_seen"}, seen, 1);
   endtask

   task automatic run_to_pos(input int pos, input int budget, input string tag);
      bit hit;
      hit = 0;
      for (int i = 0; i < budget && !hit; i++) begin
         tick();
         if (m_stream && (cyc - (m_next_due - FB)) == pos) hit = 1;
      end
      check({tag, "_pos_reached"}, hit, 1);
   endtask

   task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
      in_valid = 1'b1; in_left = l; in_right = r;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ser_start"}, ser_start, 0);
      check({tag, "_ser_left"}, ser_left, 0);
      check({tag, "_ser_right"}, ser_right, 0);
      check({tag, "_running"}, running, 0);
      check({tag, "_fifo_level"}, fifo_level, 0);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_underflow"}, underflow, 0);
      check({tag, "_underflow_count"}, underflow_count, 0);
      check({tag, "_frame_error"}, frame_error, 0);
   endtask

   initial begin
      int lvl2_cyc, prev_start, starts_before;
      logic [DW-1:0] keep_l, keep_r;

      // Reset
      reset_n = 1'b0;
      tick(); tick();
      check_reset_outputs("rst");

      // Prime and steady state with the two reference pairs
      reset_n = 1'b1; enable = 1'b1;
      push_pair(24'hA5A5A5, 24'h5A5A5A);
      push_pair(24'h123456, 24'h654321);
      check("t1_level_two", fifo_level, 2);
      lvl2_cyc = cyc;
      wait_start(5, "t1_first");
      check("t1_first_latency", last_start - lvl2_cyc, 1);
      check("t1_first_left", ser_left, 24'hA5A5A5);
      check("t1_first_right", ser_right, 24'h5A5A5A);
      prev_start = last_start;
      wait_start(FB + 5, "t1_second");
      check("t1_frame_spacing", last_start - prev_start, FB);
      check("t1_second_left", ser_left, 24'h123456);

      // Underflow on the third frame, then two more
      wait_start(FB + 5, "t2_third");
      check("t2_uf_left", ser_left, 0);
      check("t2_uf_right", ser_right, 0);
      check("t2_uf_flag", underflow, 1);
      check("t2_uf_count1", underflow_count, 1);
      wait_start(FB + 5, "t2_fourth");
      wait_start(FB + 5, "t2_fifth");
      check("t2_uf_count3", underflow_count, 3);
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      check("t2_cleared_count", underflow_count, 0);
      check("t2_cleared_flag", underflow, 0);

      // Disable mid-frame: frame completes, no further launch, FIFO kept
      push_pair(DW'($urandom), DW'($urandom));
      run_to_pos(10, FB + 5, "t3");
      enable = 1'b0;
      starts_before = n_starts;
      repeat (60) tick();
      check("t3_no_start", n_starts - starts_before, 0);
      check("t3_running_low", running, 0);
      check("t3_level_kept", fifo_level, 1);

      // Backpressure with a continuously valid source
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_left = DW'($urandom); in_right = DW'($urandom);
         tick();
      end
      check("t4_full_level", fifo_level, 4);
      check("t4_full_not_ready", in_ready, 0);
      enable = 1'b1;
      tick();
      wait_start(5, "t4_launch");
      check("t4_after_pop_level", fifo_level, 3);
      check("t4_after_pop_ready", in_ready, 1);
      in_left = DW'($urandom); in_right = DW'($urandom);
      tick();
      check("t4_refill_level", fifo_level, 4);
      check("t4_refill_not_ready", in_ready, 0);
      in_valid = 1'b0;

      // Frame error when the serializer never reports completion
      wait_start(FB + 5, "t5_pre");
      ser_data_ready = 1'b0;
      wait_start(FB + 5, "t5_end");
      check("t5_frame_error_set", frame_error, 1);
      ser_data_ready = 1'b1;
      repeat (20) tick();
      check("t5_frame_error_sticky", frame_error, 1);
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      check("t5_frame_error_cleared", frame_error, 0);

      // Random traffic
      for (int i = 0; i < 900; i++) begin
         in_valid       = ($urandom_range(0, 2) != 0);
         in_left        = DW'($urandom);
         in_right       = DW'($urandom);
         ser_data_ready = ($urandom_range(0, 9) != 0);
         clear_status   = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 199) == 0) enable = ~enable;
         tick();
      end
      in_valid = 1'b0; clear_status = 1'b0; ser_data_ready = 1'b1;

      // Reset in the middle of a running frame
      enable = 1'b1;
      for (int i = 0; i < 3; i++) push_pair(DW'($urandom), DW'($urandom));
      wait_start(FB + 10, "t6_run");
      run_to_pos(30, FB + 5, "t6");
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_reset_outputs("t6_rst");
      starts_before = n_starts;
      repeat (100) tick();
      check("t6_no_start_unprimed", n_starts - starts_before, 0);
      keep_l = DW'($urandom); keep_r = DW'($urandom);
      push_pair(keep_l, keep_r);
      push_pair(DW'($urandom), DW'($urandom));
      wait_start(5, "t6_reprime");
      check("t6_reprime_left", ser_left, keep_l);
      check("t6_reprime_right", ser_right, keep_r);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/i2s_out_sequencer.md
# i2s_out_sequencer

Frame scheduler and sample buffer for the I2S DAC serializer. It accepts stereo samples from the upstream audio source over a valid/ready handshake and buffers them in a small FIFO. Once per frame it issues a one-cycle start to the serializer with a held left/right sample pair. It also detects underflow and frame overrun. It runs entirely in the BCLK domain, between the audio source and the serializer.

## Interface
- DATA_WIDTH, 24: bits per channel sample.
- FRAME_BCLKS, 64: BCLK cycles per stereo frame; must be ≥ 2*DATA_WIDTH+1.
- FIFO_DEPTH, 4: sample-pair FIFO entries; must be a power of 2 and ≥ 2.
- PRIME_LEVEL, 2: FIFO level required before the first frame starts; must be in 1..FIFO_DEPTH.
- BCLK  in  1  sole clock; all logic updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  run request.
- clear_status  in  1  clears the sticky status outputs.
- in_valid  in  1  upstream sample pair is valid.
- in_ready  out  1  FIFO can accept a pair.
- in_left  in  DATA_WIDTH  left sample.
- in_right  in  DATA_WIDTH  right sample.
- ser_start  out  1  one-cycle frame start to the serializer.
- ser_left  out  DATA_WIDTH  left sample presented to the serializer; held stable for the whole frame.
- ser_right  out  DATA_WIDTH  right sample presented to the serializer; held stable for the whole frame.
- ser_data_ready  in  1  serializer frame-complete flag.
- running  out  1  high while in RUN.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underflow  out  1  sticky: a frame was issued with the FIFO empty.
- underflow_count  out  16  number of underflow frames; saturates at 16'hFFFF.
- frame_error  out  1  sticky: serializer had not completed a frame by the end of the frame.

## Operation
- States: IDLE, PRIME, RUN.
- IDLE
  - ser_start=0, frame_cnt=0, running=0.
  - enable=1 → PRIME.
- PRIME
  - enable=0 → IDLE.
  - fifo_level ≥ PRIME_LEVEL → RUN, with frame_cnt=0 and the first frame launched on the same edge.
- RUN
  - frame_cnt increments every cycle and wraps FRAME_BCLKS-1 → 0.
  - Every edge on which frame_cnt becomes 0 is a frame launch:
    - ser_start=1 for that cycle only.
    - FIFO pops one pair into ser_left/ser_right.
    - If the FIFO is empty, ser_left/ser_right load 0, underflow is set, and underflow_count increments (saturating).
- Disable during RUN:
  - The edge where frame_cnt would wrap is taken as a transition to IDLE instead of a launch.
  - The current frame always completes; ser_left/ser_right keep their last values.
  - FIFO contents are retained.
- Frame check: in RUN, at frame_cnt==FRAME_BCLKS-1, ser_data_ready==0 sets frame_error.
- FIFO
  - in_ready = (fifo_level < FIFO_DEPTH), decoded from the registered level.
  - Push on in_valid&&in_ready.
  - Simultaneous push and pop gives no net level change.
  - The FIFO never accepts a push when full and never pops when empty.
  - Pointers wrap modulo FIFO_DEPTH.
- clear_status clears underflow, underflow_count and frame_error. If a new underflow event occurs in the same cycle, the event wins: underflow=1, underflow_count=1.

## Timing
- Reset (reset_n=0 at an edge):
  - State IDLE; FIFO emptied.
  - Outputs: ser_start=0, ser_left=0, ser_right=0, running=0, fifo_level=0, underflow=0, underflow_count=0, frame_error=0.
  - in_ready=1 from the following cycle.
  - Reset mid-frame aborts the frame immediately. The serializer resynchronizes on the next ser_start.
- All outputs except in_ready are registered.
- Launch edge E0 raises ser_start. The serializer samples it at E1 and shifts bits at E1..E(2*DATA_WIDTH). ser_data_ready is therefore high from frame_cnt=2*DATA_WIDTH onward.
- Launches are exactly FRAME_BCLKS cycles apart while in RUN.
- PRIME→RUN: the first ser_start occurs on the edge after fifo_level reaches PRIME_LEVEL.
- Push-to-visibility: a push at edge N makes fifo_level increase at edge N. That pair can be popped at any launch edge ≥ N+1.

## Test plan
- Reset, prime, steady state:
  - Stimulus: reset, enable=1, push pairs (0xA5A5A5, 0x5A5A5A) and (0x123456, 0x654321).
  - Required: first ser_start one cycle after fifo_level=2, with ser_left=0xA5A5A5; second ser_start exactly 64 cycles later, with ser_left=0x123456.
- Underflow:
  - Stimulus: prime with 2 pairs, then stop pushing.
  - Required: third frame has ser_left=ser_right=0, underflow=1, underflow_count=1; count is 3 after two more frames.
  - Then assert clear_status → count returns to 0.
- Backpressure:
  - Stimulus: hold in_valid=1 before enable.
  - Required: in_ready drops after 4 pushes with fifo_level=4; after the first launch, one push is accepted in the cycle after the pop.
- Disable mid-frame:
  - Stimulus: drop enable at frame_cnt=10.
  - Required: no ser_start at the next wrap; running=0 at that edge; fifo_level unchanged.
- Frame error:
  - Stimulus: hold ser_data_ready=0 through a frame.
  - Required: frame_error=1 after frame_cnt=63; it stays set until clear_status.
- Reset mid-run:
  - Stimulus: reset_n=0 for one edge at frame_cnt=30.
  - Required: all outputs at their reset values; IDLE; a re-prime is required before the next ser_start.
